divide_iterative: RTL and testbench

//  Sequential IEEE-754 single-precision divider, out = inputA / inputB; the inverse operation of the
//  TPU's combinational FP32 multiplier. Uses restoring mantissa division, one quotient bit per clock.

---
 rtl/divide_iterative.sv | 118 +++++++++++
 tb/tb_divide_iterative.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/divide_iterative.sv
// Sequential FP32 divider: restoring mantissa division, one quotient bit per clock,
// truncating result, denormals treated as zero, start/busy/done handshake.
module divide_iterative #(
  parameter int QUOTIENT_BITS = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] inputA,
  input  logic [31:0] inputB,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        divByZero
);

  localparam int MSB = QUOTIENT_BITS - 1;
  localparam int CW  = $clog2(QUOTIENT_BITS);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic                     sign;
  logic [7:0]               exp_a;
  logic [7:0]               exp_b;
  logic [24:0]              rem;
  logic [24:0]              dvs;
  logic [24:0]              diff;
  logic [QUOTIENT_BITS-1:0] q;
  logic signed [9:0]        e_base;
  logic signed [9:0]        e_norm;
  logic [22:0]              frac;
  logic [32:0]              result;

  // Returns {divByZero, out}; special cases are checked in priority order.
  function automatic logic [32:0] pack_result(input logic sgn, input logic [7:0] ea,
                                              input logic [7:0] eb, input logic signed [9:0] e,
                                              input logic [22:0] f);
    if (ea == 8'hFF || eb == 8'hFF) return {1'b0, 32'h7FC0_0000};
    if (eb == 8'h00) return (ea == 8'h00) ? {1'b1, 32'h7FC0_0000} : {1'b1, sgn, 8'hFF, 23'h0};
    if (ea == 8'h00) return {1'b0, sgn, 31'h0};
    if (e >= 10'sd255) return {1'b0, sgn, 8'hFF, 23'h0};
    if (e <= 10'sd0) return {1'b0, sgn, 31'h0};
    return {1'b0, sgn, e[7:0], f};
  endfunction

  assign diff = rem - dvs;

  // Quotient lies in [0.5, 2): a clear integer bit means one extra normalising shift.
  always_comb begin
    e_base = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 10'sd127;
    e_norm = e_base;
    frac   = q[MSB-1 -: 23];
    if (!q[MSB]) begin
      e_norm = e_base - 10'sd1;
      frac   = q[MSB-2 -: 23];
    end
    result = pack_result(sign, exp_a, exp_b, e_norm, frac);
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      sign  <= inputA[31] ^ inputB[31];
      exp_a <= inputA[30:23];
      exp_b <= inputB[30:23];
      rem   <= {2'b01, inputA[22:0]};
      dvs   <= {2'b01, inputB[22:0]};
      q     <= '0;
    end else if (state == DIVIDE) begin
      if (rem >= dvs) begin
        q   <= {q[MSB-1:0], 1'b1};
        rem <= diff << 1;
      end else begin
        q   <= {q[MSB-1:0], 1'b0};
        rem <= rem << 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out       <= 32'h0;
      divByZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= DIVIDE;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        DIVIDE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(QUOTIENT_BITS - 1)) state <= NORM;
        end
        NORM: begin
          {divByZero, out} <= result;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_iterative.sv
// Scoreboard bench for divide_iterative: directed operands with hand-computed quotients.
module tb_divide_iterative;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] inputA;
  logic [31:0] inputB;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        divByZero;

  typedef struct {
    logic [31:0] o;
    logic        d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  divide_iterative #(.QUOTIENT_BITS(25)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inputA(inputA), .inputB(inputB),
    .busy(busy), .done(done), .out(out), .divByZero(divByZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out", out, e.o);
        chk("divByZero", {31'h0, divByZero}, {31'h0, e.d});
      end
    end
  end

  // Issue one operation and follow it to completion. junk=1 pulses start with other
  // operands mid-operation and again in the DONE cycle; both must be ignored.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eo, input logic ed, input bit junk);
    int cycles;
    sb.push_back('{o: eo, d: ed});
    inputA = a;
    inputB = b;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < 100) begin
      if (busy !== 1'b1) chk("busy_during_op", {31'h0, busy}, 32'd1);
      if (junk && (cycles == 5 || cycles == 10)) begin
        inputA = 32'h4120_0000 ^ a;
        inputB = 32'h3F00_0000;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    chk("latency", cycles, 27);
    chk("busy_in_done", {31'h0, busy}, 32'd1);
    if (junk) begin
      inputA = 32'h4000_0000;
      inputB = 32'h4000_0000;
      start  = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", {31'h0, busy}, 32'd0);
    chk("done_one_cycle", {31'h0, done}, 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    inputA = 32'h0;
    inputB = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_out", out, 32'h0);
    chk("rst_dbz", {31'h0, divByZero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0); // 6/2
    run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 1'b0); // 1/3 truncated
    run_op(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1, 1'b0); // -1/0
    run_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1, 1'b0); // 0/0
    run_op(32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 1'b0, 1'b0); // -0/5
    run_op(32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000, 1'b0, 1'b0); // 1/-1
    run_op(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 1'b0, 1'b0); // overflow
    run_op(32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b0); // underflow flush
    run_op(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0); // NaN in
    run_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0); // inf/0: NaN wins
    run_op(32'h4120_0000, 32'h40A0_0000, 32'h4000_0000, 1'b0, 1'b1); // 10/5 with ignored starts
    run_op(32'h3FC0_0000, 32'h3F00_0000, 32'h4040_0000, 1'b0, 1'b0); // back-to-back 1.5/0.5

    // Reset during DIVIDE cycle 10 aborts the operation without a done pulse.
    inputA = 32'h40C0_0000;
    inputB = 32'h4000_0000;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", {31'h0, busy}, 32'd0);
    chk("midrst_done", {31'h0, done}, 32'd0);
    chk("midrst_out", out, 32'h0);
    chk("midrst_dbz", {31'h0, divByZero}, 32'd0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done !== 1'b0) chk("midrst_no_done", {31'h0, done}, 32'd0);
    end

    run_op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0); // 1/1 after reset

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
